pet_status_engine: RTL and testbench

Upstream state engine for the virtual-pet LCD display. It tracks four need levels (health, food, energy, fun), decays them on a slow time base, and applies player button actions. It runs an AWAKE/SLEEP/DEAD life state machine and encodes the result as the `select_figures[3:0]` and `sleep[1:0]` codes consumed by the LCD view controller.

---
 rtl/pet_status_engine.sv | 230 +++++++++++++++++++++++
 tb/tb_pet_status_engine.sv | 182 ++++++++++++++++++
 2 files changed

// File: rtl/pet_status_engine.sv
// -----------------------------------------------------------------------------
// pet_status_engine
//
// Need tracker and life-state machine for the virtual-pet LCD. Four need levels
// (health, food, energy, fun) decay on a slow time base and are topped up by
// player buttons. An AWAKE/SLEEP/DEAD FSM gates what the buttons and decay do,
// and the outcome is encoded as mood/shown-need and sleep codes for the LCD
// view controller.
//
// Ports
//   clk            in   system clock
//   reset          in   synchronous, active-low
//   btn_feed       in   single-cycle pulse: +BTN_STEP food   (AWAKE only)
//   btn_play       in   single-cycle pulse: +BTN_STEP fun    (AWAKE only)
//   btn_heal       in   single-cycle pulse: +BTN_STEP health (AWAKE only)
//   btn_sleep      in   single-cycle pulse: AWAKE <-> SLEEP toggle
//   select_figures out  [3:2] mood (01 happy, 00 sad, 10 neutral)
//                       [1:0] lowest need (00 health, 10 food, 01 energy, 11 fun)
//   sleep          out  00 awake, 01 sleeping, 11 dead
//   levels         out  {health, food, energy, fun}, 3 bits each
//
// All outputs come straight from registers so a slow-clock consumer can sample
// them without seeing combinational glitches.
// -----------------------------------------------------------------------------
module pet_status_engine #(
   parameter int TICK_CYCLES = 50_000_000,
   parameter int DECAY_TICKS = 10,
   parameter int MAX_LEVEL   = 7,
   parameter int INIT_LEVEL  = 7,
   parameter int BTN_STEP    = 2,
   parameter int HAPPY_TH    = 5,
   parameter int SAD_TH      = 2
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        btn_feed,
   input  logic        btn_play,
   input  logic        btn_heal,
   input  logic        btn_sleep,
   output logic [3:0]  select_figures,
   output logic [1:0]  sleep,
   output logic [11:0] levels
);

   localparam int TW = (TICK_CYCLES > 1) ? $clog2(TICK_CYCLES) : 1;
   localparam int DW = (DECAY_TICKS > 1) ? $clog2(DECAY_TICKS) : 1;
   localparam logic [TW-1:0] TICK_LAST  = TW'(TICK_CYCLES - 1);
   localparam logic [DW-1:0] DECAY_LAST = DW'(DECAY_TICKS - 1);

   localparam logic [2:0] MAX3   = 3'(MAX_LEVEL);
   localparam logic [2:0] INIT3  = 3'(INIT_LEVEL);
   localparam logic [2:0] HAPPY3 = 3'(HAPPY_TH);
   localparam logic [2:0] SAD3   = 3'(SAD_TH);
   localparam logic [4:0] MAX5   = 5'(MAX_LEVEL);
   localparam logic [4:0] STEP5  = 5'(BTN_STEP);

   // Need indices; the array order matches the packing of levels.
   localparam int H = 0;   // health
   localparam int F = 1;   // food
   localparam int E = 2;   // energy
   localparam int P = 3;   // fun (play)

   typedef enum logic [1:0] {
      ST_AWAKE = 2'd0,
      ST_SLEEP = 2'd1,
      ST_DEAD  = 2'd2
   } state_t;

   state_t          state_q, state_d;
   logic [TW-1:0]   tick_cnt_q, tick_cnt_d;
   logic [DW-1:0]   decay_cnt_q, decay_cnt_d;
   logic [2:0]      lvl_q [4];
   logic [2:0]      lvl_d [4];
   logic [3:0]      sel_q, sel_d;
   logic [1:0]      sleep_q, sleep_d;

   logic            tick, decay;
   logic            awake, asleep, alive, any_zero;
   logic [3:0]      btn_en, sub_en, add_en;
   logic [3:0]      sad_vec, happy_vec;
   logic [1:0]      mood;
   logic [1:0]      min_idx;
   logic [2:0]      min_val;

   // Button, decay and sleep-recharge combined in one sum so that a button and
   // a decay landing together give sat(level - 1 + BTN_STEP). The sum is kept
   // wide enough that level + step never wraps before clamping.
   function automatic logic [2:0] step_level(input logic [2:0] lvl,
                                             input logic       btn,
                                             input logic       sub,
                                             input logic       add);
      logic [4:0] s;
      s = {2'b00, lvl} + (btn ? STEP5 : 5'd0) + (add ? 5'd1 : 5'd0);
      if (sub) begin
         s = (s == 5'd0) ? 5'd0 : s - 5'd1;
      end
      if (s > MAX5) begin
         s = MAX5;
      end
      return s[2:0];
   endfunction

   // ---------------------------------------------------------------- time base
   always_comb begin
      tick        = (tick_cnt_q == TICK_LAST);
      decay       = tick && (decay_cnt_q == DECAY_LAST);
      tick_cnt_d  = tick ? '0 : tick_cnt_q + 1'b1;
      decay_cnt_d = decay_cnt_q;
      if (tick) begin
         decay_cnt_d = (decay_cnt_q == DECAY_LAST) ? '0 : decay_cnt_q + 1'b1;
      end
   end

   // --------------------------------------------------------- per-need control
   always_comb begin
      awake    = (state_q == ST_AWAKE);
      asleep   = (state_q == ST_SLEEP);
      alive    = awake || asleep;
      // Health only drains when another need was already empty before decay.
      any_zero = (lvl_q[F] == 3'd0) || (lvl_q[E] == 3'd0) || (lvl_q[P] == 3'd0);

      btn_en = '0;
      sub_en = '0;
      add_en = '0;

      btn_en[H] = awake && btn_heal;
      btn_en[F] = awake && btn_feed;
      btn_en[P] = awake && btn_play;

      sub_en[H] = alive && decay && any_zero;
      sub_en[F] = alive && decay;
      sub_en[E] = awake && decay;
      sub_en[P] = alive && decay;

      // Sleeping recharges energy instead of draining it.
      add_en[E] = asleep && decay;
   end

   generate
      for (genvar gi = 0; gi < 4; gi++) begin : g_need
         assign lvl_d[gi]     = step_level(lvl_q[gi], btn_en[gi], sub_en[gi], add_en[gi]);
         assign sad_vec[gi]   = (lvl_q[gi] <= SAD3);
         assign happy_vec[gi] = (lvl_q[gi] >= HAPPY3);
      end
   endgenerate

   // --------------------------------------------------------- life-state FSM
   // Death is checked first so it wins over any sleep/wake in the same cycle.
   always_comb begin
      state_d = state_q;
      case (state_q)
         ST_AWAKE: begin
            if (lvl_d[H] == 3'd0) begin
               state_d = ST_DEAD;
            end else if (btn_sleep) begin
               state_d = ST_SLEEP;
            end
         end
         ST_SLEEP: begin
            if (lvl_d[H] == 3'd0) begin
               state_d = ST_DEAD;
            end else if (btn_sleep || (lvl_d[E] == MAX3)) begin
               state_d = ST_AWAKE;
            end
         end
         ST_DEAD:  state_d = ST_DEAD;
         default:  state_d = ST_AWAKE;
      endcase
   end

   // ------------------------------------------------------------ output decode
   // Decoded from the registered levels/state, so these outputs trail the
   // level registers by one cycle.
   always_comb begin
      if (|sad_vec) begin
         mood = 2'b00;
      end else if (&happy_vec) begin
         mood = 2'b01;
      end else begin
         mood = 2'b10;
      end

      // Strict less-than keeps the earlier (higher-priority) need on ties.
      min_idx = 2'd0;
      min_val = lvl_q[H];
      for (int i = 1; i < 4; i++) begin
         if (lvl_q[i] < min_val) begin
            min_val = lvl_q[i];
            min_idx = 2'(i);
         end
      end

      // Need code is the index with its two bits swapped (food=10, energy=01).
      sel_d = {mood, min_idx[0], min_idx[1]};

      case (state_q)
         ST_DEAD:  sleep_d = 2'b11;
         ST_SLEEP: sleep_d = 2'b01;
         default:  sleep_d = 2'b00;
      endcase
   end

   // ---------------------------------------------------------------- registers
   always_ff @(posedge clk) begin
      if (!reset) begin
         state_q     <= ST_AWAKE;
         tick_cnt_q  <= '0;
         decay_cnt_q <= '0;
         for (int i = 0; i < 4; i++) begin
            lvl_q[i] <= INIT3;
         end
         sel_q       <= 4'b0100;
         sleep_q     <= 2'b00;
      end else begin
         state_q     <= state_d;
         tick_cnt_q  <= tick_cnt_d;
         decay_cnt_q <= decay_cnt_d;
         for (int i = 0; i < 4; i++) begin
            lvl_q[i] <= lvl_d[i];
         end
         sel_q       <= sel_d;
         sleep_q     <= sleep_d;
      end
   end

   assign levels         = {lvl_q[H], lvl_q[F], lvl_q[E], lvl_q[P]};
   assign select_figures = sel_q;
   assign sleep          = sleep_q;

endmodule

// File: tb/tb_pet_status_engine.sv
// -----------------------------------------------------------------------------
// tb_pet_status_engine
//
// Directed bench for pet_status_engine with TICK_CYCLES=4, DECAY_TICKS=2, so a
// decay lands on every 8th clock edge after reset release. cnt counts edges
// since release; all samples are taken 1 time unit after the edge.
// -----------------------------------------------------------------------------
module tb_pet_status_engine;

   logic        clk = 1'b0;
   logic        reset;
   logic        btn_feed, btn_play, btn_heal, btn_sleep;
   logic [3:0]  select_figures;
   logic [1:0]  sleep;
   logic [11:0] levels;

   int cnt    = 0;
   int passed = 0;
   int total  = 0;

   pet_status_engine #(
      .TICK_CYCLES (4),
      .DECAY_TICKS (2),
      .MAX_LEVEL   (7),
      .INIT_LEVEL  (7),
      .BTN_STEP    (2),
      .HAPPY_TH    (5),
      .SAD_TH      (2)
   ) dut (
      .clk            (clk),
      .reset          (reset),
      .btn_feed       (btn_feed),
      .btn_play       (btn_play),
      .btn_heal       (btn_heal),
      .btn_sleep      (btn_sleep),
      .select_figures (select_figures),
      .sleep          (sleep),
      .levels         (levels)
   );

   always #5 clk = ~clk;

   task automatic cyc(input int n);
      repeat (n) @(posedge clk);
      #1;
      cnt += n;
   endtask

   task automatic go_to(input int t);
      while (cnt < t) cyc(1);
   endtask

   // Drive buttons so they are sampled on edge number e.
   task automatic press(input int e, input logic f, input logic p,
                        input logic h, input logic s);
      go_to(e - 1);
      btn_feed  = f;
      btn_play  = p;
      btn_heal  = h;
      btn_sleep = s;
      cyc(1);
      btn_feed  = 1'b0;
      btn_play  = 1'b0;
      btn_heal  = 1'b0;
      btn_sleep = 1'b0;
   endtask

   task automatic chk(input string tag, input logic [11:0] obs, input logic [11:0] exp);
      total++;
      assert (obs === exp) begin
         passed++;
         $display("check %-14s cnt=%0d observed=%h expected=%h ok", tag, cnt, obs, exp);
      end else begin
         $error("FAIL %s cnt=%0d observed=%h expected=%h", tag, cnt, obs, exp);
      end
   endtask

   initial begin
      reset     = 1'b0;
      btn_feed  = 1'b0;
      btn_play  = 1'b0;
      btn_heal  = 1'b0;
      btn_sleep = 1'b0;

      // ---- reset values
      cyc(3);
      chk("rst_levels", levels, 12'hFFF);
      chk("rst_sel", {8'd0, select_figures}, 12'h004);
      chk("rst_sleep", {10'd0, sleep}, 12'h000);
      reset = 1'b1;
      cnt   = 0;

      // ---- saturation: feed/heal at full level stay at 7
      press(3, 1'b1, 1'b0, 1'b1, 1'b0);
      chk("sat_full", levels, 12'hFFF);

      // ---- first decay exactly on edge 8
      go_to(7);
      chk("pre_decay", levels, 12'hFFF);
      go_to(8);
      chk("decay1", levels, 12'hFB6);          // {7,6,6,6}
      chk("sel_lag", {8'd0, select_figures}, 12'h004);
      go_to(9);
      chk("sel_decay1", {8'd0, select_figures}, 12'h006); // happy, food shown

      // ---- five decays: sad, food shown by tie priority
      go_to(40);
      chk("decay5", levels, 12'hE92);          // {7,2,2,2}
      go_to(41);
      chk("sel_sad_tie", {8'd0, select_figures}, 12'h002);
      press(42, 1'b1, 1'b1, 1'b0, 1'b0);
      chk("feed_play", levels, 12'hF14);       // {7,4,2,4}
      go_to(43);
      chk("sel_energy", {8'd0, select_figures}, 12'h001);

      // ---- feed coinciding with decay (food 3 -> 4)
      press(56, 1'b1, 1'b0, 1'b0, 1'b0);
      chk("coincide", levels, 12'hF02);        // {7,4,0,2}

      // ---- sleep
      press(58, 1'b0, 1'b0, 1'b0, 1'b1);
      chk("sleep_lag", {10'd0, sleep}, 12'h000);
      go_to(59);
      chk("sleep_on", {10'd0, sleep}, 12'h001);
      press(60, 1'b1, 1'b0, 1'b0, 1'b0);       // ignored while asleep
      go_to(64);
      chk("sleep_dec1", levels, 12'hCC9);      // {6,3,1,1}
      go_to(72);
      chk("sleep_dec2", levels, 12'hC90);      // {6,2,2,0}
      go_to(112);
      chk("energy_full", levels, 12'h238);     // {1,0,7,0}
      chk("still_asleep", {10'd0, sleep}, 12'h001);
      go_to(113);
      chk("auto_wake", {10'd0, sleep}, 12'h000);

      // ---- death
      go_to(120);
      chk("death_lvls", levels, 12'h030);      // {0,0,6,0}
      go_to(121);
      chk("dead_code", {10'd0, sleep}, 12'h003);
      chk("dead_sel", {8'd0, select_figures}, 12'h000);
      for (int i = 0; i < 100; i++) begin
         btn_feed  = (i % 2 == 0);
         btn_play  = (i % 3 == 0);
         btn_heal  = (i % 5 == 0);
         btn_sleep = (i % 7 == 0);
         cyc(1);
      end
      btn_feed  = 1'b0;
      btn_play  = 1'b0;
      btn_heal  = 1'b0;
      btn_sleep = 1'b0;
      chk("frozen_lvls", levels, 12'h030);
      chk("frozen_code", {10'd0, sleep}, 12'h003);

      // ---- reset out of DEAD
      reset = 1'b0;
      cyc(1);
      chk("rst2_levels", levels, 12'hFFF);
      chk("rst2_sel", {8'd0, select_figures}, 12'h004);
      chk("rst2_sleep", {10'd0, sleep}, 12'h000);
      reset = 1'b1;
      cnt   = 0;

      // ---- drive all needs to 3 for tie priority / neutral mood
      go_to(80);
      chk("health_drain", levels, 12'h800);    // {4,0,0,0}
      press(81, 1'b1, 1'b1, 1'b0, 1'b0);
      press(82, 1'b1, 1'b1, 1'b0, 1'b0);       // {4,4,0,4}
      press(83, 1'b0, 1'b0, 1'b0, 1'b1);       // sleep
      press(105, 1'b0, 1'b0, 1'b0, 1'b1);      // wake by button at {3,1,3,1}
      press(106, 1'b1, 1'b1, 1'b0, 1'b0);
      chk("all_three", levels, 12'h6DB);       // {3,3,3,3}
      chk("btn_wake", {10'd0, sleep}, 12'h000);
      go_to(107);
      chk("sel_neutral", {8'd0, select_figures}, 12'h008);

      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end

endmodule
